// File: rtl/mandel_iter_ctrl_if.sv
// Pixel-side and multiplier-side signals of the Mandelbrot iteration controller.
// slave is the controller's view; master is the scanner/multiplier environment.
interface mandel_iter_ctrl_if #(
   parameter int WIDTH      = 8,
   parameter int ITER_WIDTH = 8
);
   logic                        start;
   logic signed [WIDTH-1:0]     in_cr;
   logic signed [WIDTH-1:0]     in_ci;
   logic [ITER_WIDTH-1:0]       max_iter;
   logic                        busy;
   logic                        done;
   logic [ITER_WIDTH-1:0]       iter_count;
   logic                        escaped;
   logic signed [WIDTH-1:0]     mult_x;
   logic signed [WIDTH-1:0]     mult_y;
   logic                        mult_start;
   logic signed [2*WIDTH-1:0]   mult_out;
   logic                        mult_finished;

   modport slave (
      input  start, in_cr, in_ci, max_iter, mult_out, mult_finished,
      output busy, done, iter_count, escaped, mult_x, mult_y, mult_start
   );

   modport master (
      output start, in_cr, in_ci, max_iter, mult_out, mult_finished,
      input  busy, done, iter_count, escaped, mult_x, mult_y, mult_start
   );
endinterface

// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot pixel sequencer: time-shares one external signed multiplier to
// evaluate z = z^2 + c, detects |z|^2 > 4 and counts completed iterations.
module mandel_iter_ctrl #(
   parameter int WIDTH      = 8,
   parameter int FRAC       = 5,
   parameter int ITER_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   mandel_iter_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;
   typedef enum logic [1:0] {OP_XX, OP_YY, OP_XY} op_t;

   localparam int PW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 2;
   localparam logic signed [EW-1:0]    ESC_LIMIT = EW'(4 << (2 * FRAC));
   localparam logic signed [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                    state_q;
   op_t                       op_q;
   logic signed [WIDTH-1:0]   x_q, y_q, cr_q, ci_q;
   logic signed [WIDTH-1:0]   mult_x_q, mult_y_q;
   logic signed [PW-1:0]      xx_q, yy_q, xy_q;
   logic [ITER_WIDTH-1:0]     max_iter_q, iter_count_q;
   logic                      busy_q, done_q, escaped_q, mult_start_q;

   logic signed [EW-1:0]      mag_d, re_d, im_d;
   logic signed [WIDTH-1:0]   x_d, y_d;
   logic                      escape_d;
   logic [ITER_WIDTH-1:0]     iter_next_d;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
      if (v > EW'(SAT_MAX))      return SAT_MAX;
      else if (v < EW'(SAT_MIN)) return SAT_MIN;
      else                       return v[WIDTH-1:0];
   endfunction

   // Full-precision z^2 + c; products carry 2*FRAC fractional bits.
   always_comb begin
      mag_d       = EW'(xx_q) + EW'(yy_q);
      escape_d    = mag_d > ESC_LIMIT;
      re_d        = ((EW'(xx_q) - EW'(yy_q)) >>> FRAC) + EW'(cr_q);
      im_d        = ((EW'(xy_q) <<< 1) >>> FRAC) + EW'(ci_q);
      x_d         = sat(re_d);
      y_d         = sat(im_d);
      iter_next_d = iter_count_q + ITER_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_XX;
         x_q          <= '0;
         y_q          <= '0;
         cr_q         <= '0;
         ci_q         <= '0;
         mult_x_q     <= '0;
         mult_y_q     <= '0;
         xx_q         <= '0;
         yy_q         <= '0;
         xy_q         <= '0;
         max_iter_q   <= '0;
         iter_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         escaped_q    <= 1'b0;
         mult_start_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  cr_q         <= bus.in_cr;
                  ci_q         <= bus.in_ci;
                  max_iter_q   <= bus.max_iter;
                  x_q          <= '0;
                  y_q          <= '0;
                  iter_count_q <= '0;
                  escaped_q    <= 1'b0;
                  op_q         <= OP_XX;
                  mult_x_q     <= '0;
                  mult_y_q     <= '0;
                  busy_q       <= 1'b1;
                  if (bus.max_iter == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q      <= S_ISSUE;
                     mult_start_q <= bus.mult_finished;
                  end
               end
            end
            // NOTE: mult_start is loaded on entry to ISSUE so a ready multiplier costs
            // only one ISSUE cycle; a busy one is polled here until it goes idle.
            S_ISSUE: begin
               if (mult_start_q) begin
                  mult_start_q <= 1'b0;
                  state_q      <= S_WAIT;
               end else begin
                  mult_start_q <= bus.mult_finished;
               end
            end
            S_WAIT: begin
               if (bus.mult_finished) begin
                  case (op_q)
                     OP_XX: begin
                        xx_q         <= bus.mult_out;
                        op_q         <= OP_YY;
                        mult_x_q     <= y_q;
                        mult_y_q     <= y_q;
                        mult_start_q <= bus.mult_finished;
                        state_q      <= S_ISSUE;
                     end
                     OP_YY: begin
                        yy_q         <= bus.mult_out;
                        op_q         <= OP_XY;
                        mult_x_q     <= x_q;
                        mult_y_q     <= y_q;
                        mult_start_q <= bus.mult_finished;
                        state_q      <= S_ISSUE;
                     end
                     default: begin
                        xy_q    <= bus.mult_out;
                        state_q <= S_UPDATE;
                     end
                  endcase
               end
            end
            S_UPDATE: begin
               if (escape_d) begin
                  escaped_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  x_q          <= x_d;
                  y_q          <= y_d;
                  iter_count_q <= iter_next_d;
                  if (iter_next_d == max_iter_q) begin
                     state_q <= S_DONE;
                  end else begin
                     op_q         <= OP_XX;
                     mult_x_q     <= x_d;
                     mult_y_q     <= x_d;
                     mult_start_q <= bus.mult_finished;
                     state_q      <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.iter_count = iter_count_q;
   assign bus.escaped    = escaped_q;
   assign bus.mult_x     = mult_x_q;
   assign bus.mult_y     = mult_y_q;
   assign bus.mult_start = mult_start_q;

endmodule

// File: doc/mandel_iter_ctrl.md
Name: mandel_iter_ctrl

Overview:
Sequencer that computes one Mandelbrot pixel by time-sharing a single external bit-serial signed multiplier (WIDTH x WIDTH -> 2*WIDTH, start/finished handshake). Per iteration it issues x*x, y*y and x*y, then updates z = z^2 + c, checks for escape and counts iterations. It sits between the pixel scanner (which supplies c and collects the count) and the multiplier instance.

Parameters:
WIDTH, 8, operand width of z and c in signed fixed point; also the multiplier width.
FRAC, 5, fractional bits (Q(WIDTH-FRAC).FRAC); default range [-4.0, 4.0).
ITER_WIDTH, 8, width of max_iter and iter_count.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a new pixel; accepted only in IDLE
in_cr  in  WIDTH  real part of c, signed; sampled on accept
in_ci  in  WIDTH  imaginary part of c, signed; sampled on accept
max_iter  in  ITER_WIDTH  iteration limit; sampled on accept
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse when the result is valid
iter_count  out  ITER_WIDTH  completed iterations; held until next accept
escaped  out  1  1 = |z|^2 > 4.0 was detected; held until next accept
mult_x  out  WIDTH  multiplier operand x
mult_y  out  WIDTH  multiplier operand y
mult_start  out  1  multiplier start request
mult_out  in  2*WIDTH  multiplier product, signed, 2*FRAC fractional bits
mult_finished  in  1  multiplier idle / product valid

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, mult_start=0, iter_count=0, escaped=0, mult_x=mult_y=0, z=0.
- States: IDLE, ISSUE, WAIT, UPDATE, DONE. Op select op in {XX, YY, XY}.
- IDLE: on start, latch cr, ci and max_iter; set z=0, iter_count=0, escaped=0, op=XX. If max_iter==0, go to DONE; else go to ISSUE.
- ISSUE: drive operands (XX: x,x; YY: y,y; XY: x,y). Assert mult_start only when mult_finished=1. The cycle mult_start=1 is sampled, go to WAIT. If mult_finished=0, stay in ISSUE with mult_start=0. This covers a multiplier still running after a controller reset.
- mult_start is high for exactly one cycle per product. mult_x and mult_y are held stable from ISSUE until the product is captured. The multiplier reads its y operand every cycle.
- WAIT: on the first cycle with mult_finished=1, capture the full 2*WIDTH product into xx_p, yy_p or xy_p. Then go to ISSUE with the next op, or to UPDATE after XY.
- Multiply latency: ISSUE 1 cycle + WAIT WIDTH+1 cycles = WIDTH+2 cycles. One iteration = 3*(WIDTH+2)+1 cycles (31 at WIDTH=8).
- UPDATE, using full-precision products:
  - mag = xx_p + yy_p, at 2*WIDTH+1 bits.
  - If mag > (4 << 2*FRAC): escaped=1, go to DONE. iter_count is not incremented.
  - Otherwise:
    - x' = sat((xx_p - yy_p) >>> FRAC + cr)
    - y' = sat((xy_p <<< 1) >>> FRAC + ci)
    - Intermediates are at least 2*WIDTH+2 bits. sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Shifts are arithmetic and truncate toward negative infinity.
    - iter_count += 1. If the new iter_count == max_iter, go to DONE. Else op=XX and go to ISSUE.
- DONE: done=1 for one cycle, busy=0, then IDLE. Outputs hold.
- start while busy, or in DONE, is ignored. Input changes after accept have no effect.
- iter_count never wraps; it is bounded by max_iter.
- Reset mid-operation aborts the pixel, with no done pulse.

Test Plan:
- cr=0x00, ci=0x00, max_iter=10 -> done after 10*31+2 cycles from accept; escaped=0, iter_count=10; exactly 30 mult_start pulses.
- cr=0x40 (2.0), ci=0 -> iteration 2 gives xx=4.0 exactly, no escape, x saturates to 0x7F; iteration 3 escapes; escaped=1, iter_count=2.
- cr=0xE0 (-1.0), ci=0, max_iter=255 -> z cycles 0, -1, 0; escaped=0, iter_count=255.
- max_iter=0 -> done 2 cycles after accept, iter_count=0, escaped=0, mult_start never asserted.
- start pulsed while busy; in_cr and in_ci changed mid-run -> ignored; result matches the first request.
- Model multiplier held mult_finished=0 for 20 cycles after a rst pulse mid-WAIT -> controller stays in ISSUE with mult_start=0, then completes correctly.
